// File: rtl/ex_stage_if.sv
// ID/EX operand bundle into the execute stage and the EX/MEM writeback
// bundle plus pipeline stall request coming back out.
interface ex_stage_if;
    logic [4:0]  reg_wr_addr_in;
    logic        reg_wr_en_in;
    logic [31:0] reg_rd_data1_in;
    logic [31:0] reg_rd_data2_in;
    logic [2:0]  alusel_in;
    logic [7:0]  aluop_in;
    logic [4:0]  reg_wr_addr_out;
    logic        reg_wr_en_out;
    logic [31:0] reg_wr_data_out;
    logic        stall_req;

    modport master (
        output reg_wr_addr_in, reg_wr_en_in,
        output reg_rd_data1_in, reg_rd_data2_in,
        output alusel_in, aluop_in,
        input  reg_wr_addr_out, reg_wr_en_out,
        input  reg_wr_data_out, stall_req
    );

    modport slave (
        input  reg_wr_addr_in, reg_wr_en_in,
        input  reg_rd_data1_in, reg_rd_data2_in,
        input  alusel_in, aluop_in,
        output reg_wr_addr_out, reg_wr_en_out,
        output reg_wr_data_out, stall_req
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO pair and an optional iterative divider.
// Define EX_DIV_EN to build the 32-step restoring divider FSM.
module ex_stage (
    input logic   clk,
    input logic   rst_n,
    ex_stage_if.slave ex
);
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;
    localparam logic [2:0] SEL_HILO  = 3'd4;

    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLL   = 8'h7C;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_ADDU  = 8'h21;
    localparam logic [7:0] OP_SUBU  = 8'h23;
    localparam logic [7:0] OP_SLT   = 8'h2A;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;

    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
    logic [63:0] prod;
    logic        is_multu;
    logic        is_mthi;
    logic        is_mtlo;
    logic        div_wr;
    logic        div_stall;
    logic [31:0] div_q;
    logic [31:0] div_r;

    assign a   = ex.reg_rd_data1_in;
    assign b   = ex.reg_rd_data2_in;
    assign sh  = a[4:0];
    assign sel = ex.alusel_in;
    assign op  = ex.aluop_in;

    assign ex.reg_wr_addr_out = ex.reg_wr_addr_in;
    assign ex.reg_wr_en_out   = ex.reg_wr_en_in;
    assign ex.reg_wr_data_out = res;
    assign ex.stall_req       = div_stall;

    assign is_multu = (sel == SEL_ARITH) && (op == OP_MULTU);
    assign is_mthi  = (sel == SEL_HILO) && (op == OP_MTHI);
    assign is_mtlo  = (sel == SEL_HILO) && (op == OP_MTLO);
    assign prod     = {32'd0, a} * {32'd0, b};

    always_comb begin
        res = '0;
        case (sel)
            SEL_LOGIC: begin
                case (op)
                    OP_OR:   res = a | b;
                    OP_AND:  res = a & b;
                    OP_XOR:  res = a ^ b;
                    OP_NOR:  res = ~(a | b);
                    default: res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (op)
                    OP_SLL:  res = b << sh;
                    OP_SRL:  res = b >> sh;
                    OP_SRA:  res = $signed(b) >>> sh;
                    default: res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (op)
                    OP_ADDU: res = a + b;
                    OP_SUBU: res = a - b;
                    OP_SLT:  res = {31'd0, $signed(a) < $signed(b)};
                    default: res = '0;
                endcase
            end
            SEL_HILO: begin
                case (op)
                    OP_MFHI: res = hi;
                    OP_MFLO: res = lo;
                    default: res = '0;
                endcase
            end
            default: res = '0;
        endcase
    end

    // A finishing divide owns HI/LO; nothing else can be in EX then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (div_wr) begin
            hi <= div_r;
            lo <= div_q;
        end else if (is_multu) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
        end else begin
            if (is_mthi) hi <= a;
            if (is_mtlo) lo <= a;
        end
    end

`ifdef EX_DIV_EN
    localparam int         DIV_CYCLES = 32;
    localparam logic [5:0] LAST_STEP  = 6'(DIV_CYCLES - 1);
    localparam logic [7:0] OP_DIV     = 8'h1A;
    localparam logic [7:0] OP_DIVU    = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    div_state_t  state;
    div_state_t  state_nxt;
    logic        is_div;
    logic        sgn;
    logic        b_zero;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [5:0]  cnt;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [32:0] rem_sh;
    logic        q_bit;
    logic [32:0] rem_sub;

    assign is_div = (sel == SEL_ARITH) &&
                    ((op == OP_DIV) || (op == OP_DIVU));
    assign sgn    = (op == OP_DIV);
    assign b_zero = (b == '0);
    assign a_abs  = (sgn && a[31]) ? -a : a;
    assign b_abs  = (sgn && b[31]) ? -b : b;

    // Remainder stays below the divisor, so 33 bits hold the shifted value.
    assign rem_sh  = {rem, quo[31]};
    assign q_bit   = rem_sh >= {1'b0, dvs};
    assign rem_sub = rem_sh - {1'b0, dvs};

    assign div_q = neg_q ? -quo : quo;
    assign div_r = neg_r ? -rem : rem;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (is_div) state_nxt = b_zero ? DONE : BUSY;
            BUSY: if (cnt == LAST_STEP) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        div_stall = 1'b0;
        div_wr    = 1'b0;
        unique case (state)
            IDLE: div_stall = is_div;
            BUSY: div_stall = 1'b1;
            DONE: div_wr    = !dz;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (is_div) begin
                    dvs   <= b_abs;
                    quo   <= a_abs;
                    rem   <= '0;
                    cnt   <= '0;
                    neg_q <= sgn && (a[31] ^ b[31]);
                    neg_r <= sgn && a[31];
                    dz    <= b_zero;
                end
                BUSY: begin
                    rem <= q_bit ? rem_sub[31:0] : rem_sh[31:0];
                    quo <= {quo[30:0], q_bit};
                    cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end
`else
    assign div_stall = 1'b0;
    assign div_wr    = 1'b0;
    assign div_q     = '0;
    assign div_r     = '0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed ALU/HI-LO vectors and divider
// sequences; expectations adapt to whether EX_DIV_EN is defined.
module tb_ex_stage;
    localparam logic [2:0] S_NOP = 3'd0;
    localparam logic [2:0] S_LOG = 3'd1;
    localparam logic [2:0] S_SHF = 3'd2;
    localparam logic [2:0] S_ARI = 3'd3;
    localparam logic [2:0] S_HL  = 3'd4;

`ifdef EX_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    logic chk_vld;
    int   checks;
    int   failures;
    exp_t sb[$];

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_vld) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: output presented with no expectation");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.reg_wr_data_out !== e.data) begin
                    failures++;
                    $display("FAIL %s data: got %h want %h",
                             e.name, bus.reg_wr_data_out, e.data);
                end
                checks++;
                if ({bus.reg_wr_addr_out, bus.reg_wr_en_out,
                     bus.stall_req} !== {e.addr, e.en, 1'b0}) begin
                    failures++;
                    $display("FAIL %s ctl: got addr=%0d en=%b stall=%b want addr=%0d en=%b stall=0",
                             e.name, bus.reg_wr_addr_out, bus.reg_wr_en_out,
                             bus.stall_req, e.addr, e.en);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic en, input logic [4:0] addr);
        bus.alusel_in       = sel;
        bus.aluop_in        = op;
        bus.reg_rd_data1_in = a;
        bus.reg_rd_data2_in = b;
        bus.reg_wr_en_in    = en;
        bus.reg_wr_addr_in  = addr;
    endtask

    task automatic step(input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic en, input logic [4:0] addr,
                        input logic [31:0] exp_data, input string nm);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(sel, op, a, b, en, addr);
        sb.push_back('{exp_data, addr, en, nm});
        chk_vld = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        drive(S_NOP, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
        chk_vld = 1'b0;
    endtask

    // Holds a divide in EX until stall drops; returns at the DONE cycle.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_n,
                           input string nm);
        int n;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        drive(S_ARI, op, a, b, 1'b1, 5'd3);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall_req) break;
            n++;
        end
        checks++;
        if (n != exp_n) begin
            failures++;
            $display("FAIL %s stall_cycles: got %0d want %0d", nm, n, exp_n);
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        chk_vld  = 1'b0;
        rst_n    = 1'b0;
        drive(S_NOP, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(S_NOP, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, "reset_nop");
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd1, 32'd0, "reset_hi");
        step(S_HL, 8'h12, 32'd0, 32'd0, 1'b1, 5'd2, 32'd0, "reset_lo");

        step(S_LOG, 8'h25, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 5'd5,
             32'hF0F0_0F0F, "or");
        step(S_LOG, 8'h24, 32'hF0F0_FFFF, 32'h0FF0_0F0F, 1'b0, 5'd6,
             32'h00F0_0F0F, "and");
        step(S_LOG, 8'h26, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 5'd7,
             32'h5555_5555, "xor");
        step(S_LOG, 8'h27, 32'h0F0F_0000, 32'h0000_0F0F, 1'b1, 5'd8,
             32'hF0F0_F0F0, "nor");
        step(S_LOG, 8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd9,
             32'd0, "logic_badop");
        step(S_SHF, 8'h7C, 32'd4, 32'h0000_00FF, 1'b1, 5'd10,
             32'h0000_0FF0, "sll");
        step(S_SHF, 8'h7C, 32'h0000_0024, 32'd1, 1'b1, 5'd11,
             32'h0000_0010, "sll_mask");
        step(S_SHF, 8'h02, 32'd4, 32'h8000_0000, 1'b1, 5'd12,
             32'h0800_0000, "srl");
        step(S_SHF, 8'h03, 32'd4, 32'h8000_0000, 1'b1, 5'd13,
             32'hF800_0000, "sra_neg");
        step(S_SHF, 8'h03, 32'd31, 32'h4000_0000, 1'b1, 5'd14,
             32'd0, "sra_pos");
        step(S_ARI, 8'h21, 32'hFFFF_FFFF, 32'd2, 1'b1, 5'd15,
             32'd1, "addu_wrap");
        step(S_ARI, 8'h23, 32'd0, 32'd1, 1'b1, 5'd16,
             32'hFFFF_FFFF, "subu_wrap");
        step(S_ARI, 8'h2A, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd17,
             32'd1, "slt_neg");
        step(S_ARI, 8'h2A, 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd18,
             32'd0, "slt_pos");
        step(S_ARI, 8'h2A, 32'd5, 32'd5, 1'b1, 5'd19,
             32'd0, "slt_eq");
        step(3'd7, 8'h25, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd20,
             32'd0, "bad_class");
        step(S_NOP, 8'h25, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd21,
             32'd0, "nop_class");

        step(S_HL, 8'h11, 32'h0000_1234, 32'd0, 1'b0, 5'd0,
             32'd0, "mthi");
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd22,
             32'h0000_1234, "mfhi");
        step(S_ARI, 8'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0,
             32'd0, "multu");
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd23,
             32'hFFFF_FFFE, "multu_hi");
        step(S_HL, 8'h12, 32'd0, 32'd0, 1'b1, 5'd24,
             32'h0000_0001, "multu_lo");
        step(S_HL, 8'h13, 32'h0000_0055, 32'd0, 1'b0, 5'd0,
             32'd0, "mtlo");
        step(S_HL, 8'h12, 32'd0, 32'd0, 1'b1, 5'd25,
             32'h0000_0055, "mflo");
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd26,
             32'hFFFF_FFFE, "mtlo_keeps_hi");
        idle();

        run_div(8'h1A, 32'hFFFF_FFF9, 32'd2, DIV_ON ? 33 : 0, "div");
        step(S_HL, 8'h12, 32'd0, 32'd0, 1'b1, 5'd1,
             DIV_ON ? 32'hFFFF_FFFD : 32'h0000_0055, "div_lo");
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd2,
             DIV_ON ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, "div_hi");

        run_div(8'h1B, 32'hFFFF_FFF9, 32'd2, DIV_ON ? 33 : 0, "divu");
        step(S_HL, 8'h12, 32'd0, 32'd0, 1'b1, 5'd3,
             DIV_ON ? 32'h7FFF_FFFC : 32'h0000_0055, "divu_lo");
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd4,
             DIV_ON ? 32'h0000_0001 : 32'hFFFF_FFFE, "divu_hi");

        run_div(8'h1A, 32'd77, 32'd0, DIV_ON ? 1 : 0, "div_zero");
        step(S_HL, 8'h12, 32'd0, 32'd0, 1'b1, 5'd5,
             DIV_ON ? 32'h7FFF_FFFC : 32'h0000_0055, "div_zero_lo");
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd6,
             DIV_ON ? 32'h0000_0001 : 32'hFFFF_FFFE, "div_zero_hi");
        idle();

        @(posedge clk);
        #1;
        drive(S_ARI, 8'h1B, 32'd1000, 32'd3, 1'b1, 5'd7);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall_req) break;
            n++;
            if (n == 11) break;
        end
        checks++;
        if (n != (DIV_ON ? 11 : 0)) begin
            failures++;
            $display("FAIL abort_reach_busy: got %0d want %0d",
                     n, DIV_ON ? 11 : 0);
        end
        rst_n = 1'b0;
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd8, 32'd0, "abort_hi");
        step(S_HL, 8'h12, 32'd0, 32'd0, 1'b1, 5'd9, 32'd0, "abort_lo");
        idle();

        run_div(8'h1B, 32'd100, 32'd7, DIV_ON ? 33 : 0, "divu_100_7");
        step(S_HL, 8'h12, 32'd0, 32'd0, 1'b1, 5'd10,
             DIV_ON ? 32'd14 : 32'd0, "divu_100_7_lo");
        step(S_HL, 8'h10, 32'd0, 32'd0, 1'b1, 5'd11,
             DIV_ON ? 32'd2 : 32'd0, "divu_100_7_hi");
        idle();
        @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
